arbiter2ph: RTL
===============

Name: arbiter2ph

Overview:
- Round-robin arbiter and multiplexer that shares one two-phase (toggle) req/ack output channel among N traffic sources, such as source-style packet generators.
- Each input channel signals a new flit by toggling its req, and is answered by a toggle of its ack.
- The block forwards one flit at a time downstream, waits for the downstream ack toggle, then returns the ack to the granted source.
- Sits between a group of sources and a router or sink input port.

Parameters:
- N, 4, number of input channels (2..16).
- IDX_W, 2, width of the grant index; must satisfy 2^IDX_W >= N.
- SIZE, 8, flit data width.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk, input, 1, clock; all logic on posedge.
- reset, input, 1, synchronous active-low reset; sampled on posedge clk; reset==0 clears all state.
- in_req, input, N, per-channel two-phase request; channel i is pending while in_req[i] != in_ack[i].
- in_ack, output, N, per-channel two-phase acknowledge (registered).
- in_data, input, N*SIZE, flit of channel i at bits [i*SIZE +: SIZE]; stable while channel i is pending.
- out_req, output, 1, downstream two-phase request (registered).
- out_ack, input, 1, downstream two-phase acknowledge.
- out_data, output, SIZE, forwarded flit (registered).
- busy, output, 1, high while a transfer is outstanding (state WAIT).
- grant, output, IDX_W, index of the last or current granted channel.
- xfer_count, output, CNT_W, number of completed transfers; saturates at all-ones.

Behaviour:
- Reset (reset==0 at posedge): in_ack=0, out_req=0, out_data=0, busy=0, grant=0, xfer_count=0, rr pointer=0, state=IDLE.
  - Reset mid-transfer drops the transfer silently. Neighbours must be reset in the same cycle, because phase alignment is lost otherwise.
- pending[i] = in_req[i] ^ in_ack[i]. This is combinational from the inputs and the in_ack register.
- State IDLE, on a posedge where any pending bit is set:
  - sel = first pending index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Assign out_data <= in_data[sel], out_req <= ~out_req, grant <= sel, busy <= 1, state <= WAIT.
  - Latency: out_req toggles at the first posedge that samples the input toggle, i.e. 1 cycle.
- State IDLE, nothing pending: hold all state.
- State WAIT: the downstream ack has arrived when out_ack == out_req. On that posedge:
  - in_ack[grant] <= ~in_ack[grant], busy <= 0, state <= IDLE.
  - ptr <= (grant == N-1) ? 0 : grant+1.
  - xfer_count increments unless it is already all-ones.
- WAIT with no ack: hold. The block never times out.
- Throughput is at most one transfer per 2 cycles plus the downstream ack latency. The IDLE cycle after an ack guarantees the acked channel's pending bit has cleared before the next arbitration.
- Simultaneous pending requests: strict round-robin from ptr. A channel granted last has lowest priority next.
- A request arriving during WAIT is queued implicitly (it stays pending) and is considered in the next IDLE.
- An input toggling req twice without an ack is a protocol violation and its behaviour is undefined. A downstream ack toggle while in IDLE is likewise undefined.
- in_ack bits of non-granted channels never change.
- out_data holds its value between transfers.

Optional Feature:
- Macro: ARBITER2PH_TRACE_EN.
- When defined, simulation-only $display lines are emitted:
  - On grant: time, "Arbiter", granted index, data.
  - On ack completion: time, "Arbiter", index, "ack".
- When undefined, no display statements are compiled.
- Synthesised logic and cycle behaviour are identical in both cases.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_req=4'b1111. Required: all outputs 0 and busy=0 throughout; first grant is channel 0 on the first posedge after reset=1.
- Single channel: N=4, channel 2 toggles in_req with data 8'hA5; downstream acks 3 cycles after out_req toggles. Required:
  - out_req=1, out_data=A5, grant=2, busy=1 one cycle later.
  - in_ack[2]=1 and xfer_count=1 on the posedge after out_ack toggles.
  - busy=0.
- Round-robin: all 4 channels pending at once, with immediate downstream ack. Required: grants 0,1,2,3, each completing with an in_ack toggle; channel 0 re-requesting after its ack is served only after 3.
- Late arrival: channel 3 pending, then channel 1 toggles during WAIT. Required: channel 1 is granted in the next IDLE. Then both 1 and 3 re-request: the order is 3 then 1 (ptr=2 after channel 1 completes).
- Stall: downstream never acks for 50 cycles. Required: busy=1, out_req stable, no in_ack change. After the ack arrives, completion occurs on the next posedge.
- Saturation: CNT_W=2, 5 transfers. Required: xfer_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/arbiter2ph.sv
// Round-robin arbiter/mux of N two-phase req/ack sources onto one two-phase output channel.
// Optional simulation trace of grants and acks: define ARBITER2PH_TRACE_EN.
module arbiter2ph #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_req,
  output logic [N-1:0]      in_ack,
  input  logic [N*SIZE-1:0] in_data,
  output logic              out_req,
  input  logic              out_ack,
  output logic [SIZE-1:0]   out_data,
  output logic              busy,
  output logic [IDX_W-1:0]  grant,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  generate
    if ((2 ** IDX_W) < N) begin : g_bad_idx_w
      $error("arbiter2ph: IDX_W too small for N");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [N-1:0]     r_in_ack;
  logic             r_out_req;
  logic [SIZE-1:0]  r_out_data;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [N-1:0]     w_in_ack_nxt;
  logic             w_out_req_nxt;
  logic [SIZE-1:0]  w_out_data_nxt;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic [N-1:0]     w_pending;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic             w_dn_ack;

  assign w_pending = in_req ^ r_in_ack;
  assign w_dn_ack  = (out_ack == r_out_req);

  // First pending channel scanning ptr, ptr+1, ... with wrap at N.
  always_comb begin
    logic [SUM_W-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_idx = SUM_W'(r_ptr) + SUM_W'(k);
      if (v_idx >= SUM_W'(N)) begin
        v_idx = v_idx - SUM_W'(N);
      end
      if (!w_found && w_pending[v_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_idx[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_in_ack_nxt   = r_in_ack;
    w_out_req_nxt  = r_out_req;
    w_out_data_nxt = r_out_data;
    w_busy_nxt     = r_busy;
    w_count_nxt    = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_out_data_nxt = in_data[32'(w_sel) * SIZE +: SIZE];
          w_out_req_nxt  = ~r_out_req;
          w_grant_nxt    = w_sel;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_dn_ack) begin
          w_in_ack_nxt[r_grant] = ~r_in_ack[r_grant];
          w_busy_nxt            = 1'b0;
          w_state_nxt           = S_IDLE;
          w_ptr_nxt             = (r_grant == IDX_W'(N - 1)) ? '0 : r_grant + IDX_W'(1);
          if (r_count != '1) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_in_ack   <= '0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_in_ack   <= w_in_ack_nxt;
      r_out_req  <= w_out_req_nxt;
      r_out_data <= w_out_data_nxt;
      r_busy     <= w_busy_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign in_ack     = r_in_ack;
  assign out_req    = r_out_req;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign grant      = r_grant;
  assign xfer_count = r_count;

`ifdef ARBITER2PH_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (r_state == S_IDLE && w_found) begin
        $display("%0t Arbiter %0d %h", $time, w_sel, in_data[32'(w_sel) * SIZE +: SIZE]);
      end
      if (r_state == S_WAIT && w_dn_ack) begin
        $display("%0t Arbiter %0d ack", $time, r_grant);
      end
    end
  end
`else
`endif

endmodule
